// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, branch/cmov condition
// evaluation and the M pipeline register.
module execute_stage #(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [1:0]   m_stat,
  input  logic [1:0]   W_stat,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [2:0]   cc,
  output logic [1:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  typedef enum logic [3:0] {
    I_HALT, I_NOP, I_RRMOV, I_IRMOV, I_RMMOV, I_MRMOV,
    I_OPQ, I_JXX, I_CALL, I_RET, I_PUSH, I_POP
  } icode_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alufun_e;

  typedef enum logic [1:0] {S_AOK, S_HLT, S_ADR, S_INS} stat_e;

  logic [W-1:0] alu_a, alu_b, alu_res;
  alufun_e      alufun;
  logic         of_new, zf_new, sf_new;
  logic         set_cc;
  logic         zf, sf, of, less;
  logic         cnd;
  logic         ifun_unused;

  assign ifun_unused = E_ifun[3];

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOV, I_OPQ:           alu_a = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
      I_CALL, I_PUSH:           alu_a = '0 - W'(8);
      I_RET, I_POP:             alu_a = W'(8);
      default:                  alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = E_valB;
      default:                                               alu_b = '0;
    endcase
  end

  assign alufun = (E_icode == I_OPQ) ? alufun_e'(E_ifun[1:0]) : ALU_ADD;

  // Operand order is valB OP valA, so sub yields valB - valA.
  always_comb begin
    alu_res = '0;
    of_new  = 1'b0;
    case (alufun)
      ALU_ADD: begin
        alu_res = alu_b + alu_a;
        of_new  = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        of_new  = (alu_b[W-1] != alu_a[W-1]) && (alu_res[W-1] != alu_b[W-1]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: alu_res = '0;
    endcase
  end

  assign zf_new = (alu_res == '0);
  assign sf_new = alu_res[W-1];
  assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

  assign {zf, sf, of} = cc;
  assign less         = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (E_ifun[2:0])
      3'd0:    cnd = 1'b1;
      3'd1:    cnd = less | zf;
      3'd2:    cnd = less;
      3'd3:    cnd = zf;
      3'd4:    cnd = ~zf;
      3'd5:    cnd = ~less;
      3'd6:    cnd = ~less & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  assign e_valE = alu_res;
  assign e_Cnd  = cnd;
  assign e_dstE = ((E_icode == I_RRMOV) && !cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cc <= 3'b100;
    else if (set_cc) cc <= {zf_new, sf_new, of_new};
  end

  // A bubble only squashes the M register; the CC update still happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || M_bubble) begin
      if (rst || M_bubble) begin
        M_stat  <= S_AOK;
        M_icode <= I_NOP;
        M_Cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= RNONE;
        M_dstM  <= RNONE;
      end
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= cnd;
      M_valE  <= alu_res;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_execute_stage;
  localparam int unsigned W     = 64;
  localparam logic [3:0]  RNONE = 4'hF;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   E_stat = '0;
  logic [3:0]   E_icode = 4'd1, E_ifun = '0;
  logic [W-1:0] E_valC = '0, E_valA = '0, E_valB = '0;
  logic [3:0]   E_dstE = RNONE, E_dstM = RNONE;
  logic [1:0]   m_stat = '0, W_stat = '0;
  logic         M_bubble = 1'b0;
  logic [W-1:0] e_valE, M_valE, M_valA;
  logic [3:0]   e_dstE, M_icode, M_dstE, M_dstM;
  logic         e_Cnd, M_Cnd;
  logic [2:0]   cc;
  logic [1:0]   M_stat;

  int checks = 0;
  int failures = 0;

  logic [2:0]   mcc;
  logic [W-1:0] o_valE;
  logic [3:0]   o_dstE;
  logic         o_cnd;

  execute_stage #(.W(W), .RNONE(RNONE)) dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  // Drive one instruction at the falling edge, capture the combinational
  // outputs, then let one rising edge happen and settle.
  task automatic apply(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [W-1:0] vc, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [1:0] ms, input logic [1:0] ws, input logic bub);
    @(negedge clk);
    E_stat = st; E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb;
    E_dstE = de; E_dstM = dm; m_stat = ms; W_stat = ws; M_bubble = bub;
    #1;
    o_valE = e_valE; o_dstE = e_dstE; o_cnd = e_Cnd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_valE(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [W-1:0] vc, input logic [W-1:0] va,
                                            input logic [W-1:0] vb);
    case (ic)
      4'h2:       return va;
      4'h3:       return vc;
      4'h4, 4'h5: return vb + vc;
      4'h6: case (fn[1:0])
              2'd0:    return vb + va;
              2'd1:    return vb - va;
              2'd2:    return vb & va;
              default: return vb ^ va;
            endcase
      4'h8, 4'hA: return vb - 64'd8;
      4'h9, 4'hB: return vb + 64'd8;
      default:    return '0;
    endcase
  endfunction

  // Overflow = exact signed result does not fit in W bits.
  function automatic logic [2:0] ref_cc(input logic [3:0] fn, input logic [W-1:0] va,
                                        input logic [W-1:0] vb);
    logic signed [W:0] sa, sb, t;
    logic [W-1:0] res;
    logic ovf;
    sa = $signed({va[W-1], va});
    sb = $signed({vb[W-1], vb});
    ovf = 1'b0;
    case (fn[1:0])
      2'd0: begin t = sb + sa; res = t[W-1:0]; ovf = (t > $signed({1'b0, MAXP})) || (t < -$signed({1'b0, MAXP}) - 1); end
      2'd1: begin t = sb - sa; res = t[W-1:0]; ovf = (t > $signed({1'b0, MAXP})) || (t < -$signed({1'b0, MAXP}) - 1); end
      2'd2: res = vb & va;
      default: res = vb ^ va;
    endcase
    return {res == '0, res[W-1], ovf};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] c);
    logic zf, lt;
    zf = c[2];
    lt = (c[1] != c[0]);
    case (fn[2:0])
      3'd0:    return 1'b1;
      3'd1:    return lt || zf;
      3'd2:    return lt;
      3'd3:    return zf;
      3'd4:    return !zf;
      3'd5:    return !lt;
      3'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MAXP;
      2:       return MINN;
      3:       return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (M_icode !== 4'd1) begin failures++; $display("FAIL reset_icode got=%h exp=1", M_icode); end
    checks++; if (M_stat !== 2'd0) begin failures++; $display("FAIL reset_stat got=%h exp=0", M_stat); end
    checks++; if (M_Cnd !== 1'b0) begin failures++; $display("FAIL reset_cnd got=%b exp=0", M_Cnd); end
    checks++; if (M_valE !== '0 || M_valA !== '0) begin failures++; $display("FAIL reset_vals got=%h/%h exp=0/0", M_valE, M_valA); end
    checks++; if (M_dstE !== RNONE || M_dstM !== RNONE) begin failures++; $display("FAIL reset_dst got=%h/%h exp=f/f", M_dstE, M_dstM); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", cc); end
    // Reset held across an edge must override both M load and CC update.
    @(negedge clk);
    E_stat = 2'd0; E_icode = 4'h6; E_ifun = 4'h0; E_valA = 64'd1; E_valB = 64'd1;
    E_dstE = 4'd2; E_dstM = RNONE; m_stat = 2'd0; W_stat = 2'd0; M_bubble = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (M_icode !== 4'd1 || M_dstE !== RNONE) begin failures++; $display("FAIL reset_hold_m got=%h/%h exp=1/f", M_icode, M_dstE); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL reset_hold_cc got=%b exp=100", cc); end
    @(negedge clk);
    rst = 1'b0;
    E_icode = 4'h1;
    mcc = 3'b100;
  endtask

  task automatic test_add_overflow();
    apply(2'd0, 4'h6, 4'h0, '0, MAXP, MAXP, 4'd2, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL add_ovf_valE got=%h exp=fffffffffffffffe", M_valE); end
    checks++; if (cc !== 3'b011) begin failures++; $display("FAIL add_ovf_cc got=%b exp=011", cc); end
    mcc = 3'b011;
  endtask

  // With SF=1,OF=1 the signed "less" test is false, so cmovl is not taken
  // and cmovg is.
  task automatic test_cmov();
    apply(2'd0, 4'h2, 4'h2, '0, 64'h55, '0, 4'd3, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (o_cnd !== 1'b0) begin failures++; $display("FAIL cmovl_e_cnd got=%b exp=0", o_cnd); end
    checks++; if (M_Cnd !== 1'b0 || M_dstE !== RNONE) begin failures++; $display("FAIL cmovl_m got=%b/%h exp=0/f", M_Cnd, M_dstE); end
    checks++; if (M_valE !== 64'h55) begin failures++; $display("FAIL cmovl_valE got=%h exp=55", M_valE); end
    apply(2'd0, 4'h2, 4'h6, '0, 64'h55, '0, 4'd3, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (M_Cnd !== 1'b1 || M_dstE !== 4'd3) begin failures++; $display("FAIL cmovg_m got=%b/%h exp=1/3", M_Cnd, M_dstE); end
  endtask

  task automatic test_sub_zero();
    apply(2'd0, 4'h6, 4'h1, '0, 64'd5, 64'd5, 4'd2, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (o_valE !== '0) begin failures++; $display("FAIL sub_zero_e_valE got=%h exp=0", o_valE); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL sub_zero_cc got=%b exp=100", cc); end
    checks++; if (M_valE !== '0) begin failures++; $display("FAIL sub_zero_valE got=%h exp=0", M_valE); end
    mcc = 3'b100;
  endtask

  task automatic test_cc_inhibit_stack();
    logic [W-1:0] a, b;
    a = {$urandom(), $urandom()} | 64'h1;
    b = {$urandom(), $urandom()} & ~64'h1;
    apply(2'd0, 4'h6, 4'h3, '0, a, b, 4'd4, RNONE, 2'd2, 2'd0, 1'b0);
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL xor_mstat_cc got=%b exp=100", cc); end
    checks++; if (M_valE !== (a ^ b)) begin failures++; $display("FAIL xor_mstat_valE got=%h exp=%h", M_valE, a ^ b); end
    apply(2'd0, 4'h6, 4'h0, '0, MINN, 64'd0, 4'd4, RNONE, 2'd0, 2'd3, 1'b0);
    checks++; if (cc !== 3'b100 || M_icode !== 4'h6) begin failures++; $display("FAIL add_wstat got=%b/%h exp=100/6", cc, M_icode); end
    apply(2'd0, 4'hA, 4'h0, '0, 64'd7, 64'd1024, 4'd4, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (M_valE !== 64'd1016) begin failures++; $display("FAIL push_valE got=%0d exp=1016", M_valE); end
    apply(2'd0, 4'hB, 4'h0, '0, 64'd1016, 64'd1016, 4'd4, 4'd5, 2'd0, 2'd0, 1'b0);
    checks++; if (M_valE !== 64'd1024) begin failures++; $display("FAIL pop_valE got=%0d exp=1024", M_valE); end
  endtask

  task automatic test_bubble();
    apply(2'd0, 4'h6, 4'h0, '0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 4'd5, RNONE, 2'd0, 2'd0, 1'b1);
    checks++; if (M_icode !== 4'd1 || M_valE !== '0 || M_dstE !== RNONE) begin failures++; $display("FAIL bubble_m got=%h/%h/%h exp=1/0/f", M_icode, M_valE, M_dstE); end
    checks++; if (cc !== 3'b010) begin failures++; $display("FAIL bubble_cc got=%b exp=010", cc); end
    mcc = 3'b010;
    apply(2'd0, 4'h4, 4'h0, 64'd16, 64'd10, 64'd100, RNONE, RNONE, 2'd0, 2'd0, 1'b0);
    checks++; if (M_valE !== 64'd116 || M_valA !== 64'd10) begin failures++; $display("FAIL rmmov got=%0d/%0d exp=116/10", M_valE, M_valA); end
    apply(2'd2, 4'h5, 4'h0, 64'd8, '0, 64'd40, RNONE, 4'd6, 2'd0, 2'd0, 1'b0);
    checks++; if (M_stat !== 2'd2 || M_icode !== 4'h5 || M_dstM !== 4'd6) begin failures++; $display("FAIL fault_pass got=%h/%h/%h exp=2/5/6", M_stat, M_icode, M_dstM); end
  endtask

  task automatic test_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic [1:0] st, ms, ws;
      logic [3:0] ic, fn, de, dm, x_dstE;
      logic [W-1:0] vc, va, vb, x_valE;
      logic bub, x_cnd;
      logic [2:0] x_cc;
      st = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      ic = 4'($urandom_range(0, 15));
      if (st != 2'd0 && ic == 4'h6) ic = 4'h1;
      fn = 4'($urandom_range(0, 15));
      vc = pick_val(); va = pick_val();
      vb = ($urandom_range(0, 5) == 0) ? va : pick_val();
      de = 4'($urandom_range(0, 15)); dm = 4'($urandom_range(0, 15));
      ms = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      ws = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      bub = ($urandom_range(0, 7) == 0);
      x_valE = ref_valE(ic, fn, vc, va, vb);
      x_cnd  = ref_cnd(fn, mcc);
      x_dstE = (ic == 4'h2 && !x_cnd) ? RNONE : de;
      x_cc   = (ic == 4'h6 && ms == 2'd0 && ws == 2'd0) ? ref_cc(fn, va, vb) : mcc;
      apply(st, ic, fn, vc, va, vb, de, dm, ms, ws, bub);
      checks++; if (o_valE !== x_valE) begin failures++; $display("FAIL rnd%0d e_valE got=%h exp=%h", i, o_valE, x_valE); end
      checks++; if (o_cnd !== x_cnd) begin failures++; $display("FAIL rnd%0d e_Cnd got=%b exp=%b", i, o_cnd, x_cnd); end
      checks++; if (o_dstE !== x_dstE) begin failures++; $display("FAIL rnd%0d e_dstE got=%h exp=%h", i, o_dstE, x_dstE); end
      checks++; if (cc !== x_cc) begin failures++; $display("FAIL rnd%0d cc got=%b exp=%b", i, cc, x_cc); end
      if (bub) begin
        checks++;
        if ({M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM} !==
            {2'd0, 4'd1, 1'b0, 64'd0, 64'd0, RNONE, RNONE}) begin
          failures++; $display("FAIL rnd%0d bubble got=%h/%h/%b/%h/%h/%h/%h", i, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM);
        end
      end else begin
        checks++;
        if ({M_stat, M_icode, M_Cnd, M_dstE, M_dstM} !== {st, ic, x_cnd, x_dstE, dm}) begin
          failures++; $display("FAIL rnd%0d m_ctl got=%h/%h/%b/%h/%h exp=%h/%h/%b/%h/%h", i, M_stat, M_icode, M_Cnd, M_dstE, M_dstM, st, ic, x_cnd, x_dstE, dm);
        end
        checks++;
        if (M_valE !== x_valE || M_valA !== va) begin
          failures++; $display("FAIL rnd%0d m_vals got=%h/%h exp=%h/%h", i, M_valE, M_valA, x_valE, va);
        end
      end
      mcc = x_cc;
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_cmov();
    test_sub_zero();
    test_cc_inhibit_stack();
    test_bubble();
    test_random(200);
    test_reset();
    test_random(150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
